// File: rtl/meter_io_if.sv
// Bus port of the meter_io peripheral: CPU-side select, strobes, write data and registered read data.
interface meter_io_if;
  logic        sel;
  logic [2:0]  addr;
  logic        nrd;
  logic [3:0]  nwr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, nrd, nwr, wdata, input rdata);
  modport slave  (input sel, addr, nrd, nwr, wdata, output rdata);
endinterface

// File: rtl/meter_io.sv
// Memory-mapped I/O peripheral: debounced buttons, quadrature encoder, open-drain/push-pull pins,
// periodic timer and a maskable interrupt aggregator. Reads return one clock after the strobe.
module meter_io #(
  parameter int                    IN_COUNT           = 3,
  parameter int                    OUT_COUNT          = 1,
  parameter int                    OD_COUNT           = 2,
  parameter int                    DEBOUNCE_BITS      = 16,
  parameter int                    ENC_BITS           = 16,
  parameter int                    TIMER_BITS         = 23,
  parameter logic [TIMER_BITS-1:0] TIMER_RESET_RELOAD = 23'h7FFFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  meter_io_if.slave            bus,
  input  logic [IN_COUNT-1:0]  in_pins_i,
  input  logic                 enc_a_i,
  input  logic                 enc_b_i,
  input  logic [OD_COUNT-1:0]  od_in_i,
  output logic [OD_COUNT-1:0]  od_release_o,
  output logic [OUT_COUNT-1:0] out_pins_o,
  output logic                 irq_o
);

  localparam logic [2:0] A_INPUT  = 3'd0;
  localparam logic [2:0] A_OUTPUT = 3'd1;
  localparam logic [2:0] A_ENC    = 3'd2;
  localparam logic [2:0] A_RELOAD = 3'd3;
  localparam logic [2:0] A_STAT   = 3'd4;
  localparam logic [2:0] A_EN     = 3'd5;

  logic [IN_COUNT-1:0]      in_s1_q, in_s2_q;
  logic [1:0]               enc_s1_q, enc_s2_q, enc_prev_q;
  logic [OD_COUNT-1:0]      od_s1_q, od_s2_q;
  logic [IN_COUNT-1:0]      db_q, db_d;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q [IN_COUNT];
  logic [DEBOUNCE_BITS-1:0] db_cnt_d [IN_COUNT];
  logic [OUT_COUNT-1:0]     out_q, out_d;
  logic [OD_COUNT-1:0]      od_q, od_d;
  logic [ENC_BITS-1:0]      enc_q, enc_d;
  logic [TIMER_BITS-1:0]    tmr_cnt_q, tmr_cnt_d;
  logic [TIMER_BITS-1:0]    tmr_reload_q, tmr_reload_d;
  logic [2:0]               irq_stat_q, irq_stat_d;
  logic [2:0]               irq_en_q, irq_en_d;
  logic [31:0]              rdata_q, rdata_d;

  logic        wr_en, rd_en, press, enc_up, enc_dn, tmr_evt;
  logic [31:0] byte_m, rd_word, wr_word, clr_word;
  logic        unused_bits;

  // Successor in the forward quadrature sequence 00->01->11->10->00, packed {a,b}.
  function automatic logic [1:0] enc_fwd(input logic [1:0] s);
    case (s)
      2'b00:   enc_fwd = 2'b01;
      2'b01:   enc_fwd = 2'b11;
      2'b11:   enc_fwd = 2'b10;
      default: enc_fwd = 2'b00;
    endcase
  endfunction

  assign wr_en    = bus.sel && (bus.nwr != 4'b1111);
  assign rd_en    = bus.sel && !bus.nrd;
  assign byte_m   = {{8{~bus.nwr[3]}}, {8{~bus.nwr[2]}}, {8{~bus.nwr[1]}}, {8{~bus.nwr[0]}}};
  // Byte-lane merge of write data into the current value of the addressed register.
  assign wr_word  = (rd_word & ~byte_m) | (bus.wdata & byte_m);
  assign clr_word = bus.wdata & byte_m;
  assign unused_bits = ^{wr_word, clr_word};

  assign enc_up = (enc_s2_q == enc_fwd(enc_prev_q));
  assign enc_dn = (enc_prev_q == enc_fwd(enc_s2_q));

  always_comb begin
    rd_word = '0;
    case (bus.addr)
      A_INPUT: begin
        rd_word[IN_COUNT-1:0]    = db_q;
        rd_word[16 +: OD_COUNT]  = od_s2_q;
        rd_word[24]              = enc_s2_q[1];
        rd_word[25]              = enc_s2_q[0];
      end
      A_OUTPUT: begin
        rd_word[OUT_COUNT-1:0]   = out_q;
        rd_word[16 +: OD_COUNT]  = od_q;
      end
      A_ENC:    rd_word = 32'($signed(enc_q));
      A_RELOAD: rd_word = 32'(tmr_reload_q);
      A_STAT:   rd_word[2:0] = irq_stat_q;
      A_EN:     rd_word[2:0] = irq_en_q;
      default:  rd_word = '0;
    endcase
  end

  always_comb begin
    db_d  = db_q;
    press = 1'b0;
    for (int i = 0; i < IN_COUNT; i++) begin
      db_cnt_d[i] = '0;
      if (in_s2_q[i] != db_q[i]) begin
        if (&db_cnt_q[i]) begin
          db_d[i] = in_s2_q[i];
          press   = press | db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DEBOUNCE_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    out_d        = out_q;
    od_d         = od_q;
    enc_d        = enc_q;
    tmr_cnt_d    = tmr_cnt_q;
    tmr_reload_d = tmr_reload_q;
    irq_en_d     = irq_en_q;
    tmr_evt      = 1'b0;
    rdata_d      = rd_en ? rd_word : rdata_q;

    if (wr_en && bus.addr == A_OUTPUT) begin
      out_d = wr_word[OUT_COUNT-1:0];
      od_d  = wr_word[16 +: OD_COUNT];
    end

    // A CPU load of the count takes priority over a simultaneous step.
    if (wr_en && bus.addr == A_ENC) begin
      enc_d = wr_word[ENC_BITS-1:0];
    end else if (enc_up) begin
      enc_d = enc_q + ENC_BITS'(1);
    end else if (enc_dn) begin
      enc_d = enc_q - ENC_BITS'(1);
    end

    if (wr_en && bus.addr == A_RELOAD) begin
      tmr_reload_d = wr_word[TIMER_BITS-1:0];
      tmr_cnt_d    = wr_word[TIMER_BITS-1:0];
    end else if (tmr_reload_q == '0) begin
      tmr_cnt_d = '0;
    end else if (tmr_cnt_q == '0) begin
      tmr_cnt_d = tmr_reload_q;
      tmr_evt   = 1'b1;
    end else begin
      tmr_cnt_d = tmr_cnt_q - TIMER_BITS'(1);
    end

    if (wr_en && bus.addr == A_EN) begin
      irq_en_d = wr_word[2:0];
    end

    // Hardware sets are OR'd after the clear so a coincident event is never lost.
    irq_stat_d = irq_stat_q;
    if (wr_en && bus.addr == A_STAT) begin
      irq_stat_d = irq_stat_q & ~clr_word[2:0];
    end
    irq_stat_d = irq_stat_d | {press, (enc_up || enc_dn) && !(wr_en && bus.addr == A_ENC), tmr_evt};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_s1_q      <= '1;
      in_s2_q      <= '1;
      enc_s1_q     <= '1;
      enc_s2_q     <= '1;
      enc_prev_q   <= '1;
      od_s1_q      <= '1;
      od_s2_q      <= '1;
      db_q         <= '1;
      for (int i = 0; i < IN_COUNT; i++) db_cnt_q[i] <= '0;
      out_q        <= '1;
      od_q         <= '1;
      enc_q        <= '0;
      tmr_reload_q <= TIMER_RESET_RELOAD;
      tmr_cnt_q    <= TIMER_RESET_RELOAD;
      irq_stat_q   <= '0;
      irq_en_q     <= '0;
      rdata_q      <= '0;
    end else begin
      in_s1_q      <= in_pins_i;
      in_s2_q      <= in_s1_q;
      enc_s1_q     <= {enc_a_i, enc_b_i};
      enc_s2_q     <= enc_s1_q;
      enc_prev_q   <= enc_s2_q;
      od_s1_q      <= od_in_i;
      od_s2_q      <= od_s1_q;
      db_q         <= db_d;
      for (int i = 0; i < IN_COUNT; i++) db_cnt_q[i] <= db_cnt_d[i];
      out_q        <= out_d;
      od_q         <= od_d;
      enc_q        <= enc_d;
      tmr_reload_q <= tmr_reload_d;
      tmr_cnt_q    <= tmr_cnt_d;
      irq_stat_q   <= irq_stat_d;
      irq_en_q     <= irq_en_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign od_release_o = od_q;
  assign out_pins_o   = out_q;
  assign irq_o        = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_meter_io.sv
// Directed bench for meter_io with short debounce (DEBOUNCE_BITS=3) and hand-computed expectations.
module tb_meter_io;

  localparam logic [2:0] A_INPUT  = 3'd0;
  localparam logic [2:0] A_OUTPUT = 3'd1;
  localparam logic [2:0] A_ENC    = 3'd2;
  localparam logic [2:0] A_RELOAD = 3'd3;
  localparam logic [2:0] A_STAT   = 3'd4;
  localparam logic [2:0] A_EN     = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_pins;
  logic       enc_a, enc_b;
  logic [1:0] od_in;
  logic [1:0] od_release;
  logic [0:0] out_pins;
  logic       irq;
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  meter_io_if bus ();

  meter_io #(.DEBOUNCE_BITS(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .in_pins_i    (in_pins),
    .enc_a_i      (enc_a),
    .enc_b_i      (enc_b),
    .od_in_i      (od_in),
    .od_release_o (od_release),
    .out_pins_o   (out_pins),
    .irq_o        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] n, input logic [31:0] d);
    bus.sel = 1'b1; bus.addr = a; bus.nwr = n; bus.wdata = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.nwr = 4'hF; bus.wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.addr = a; bus.nrd = 1'b0;
    @(negedge clk);
    bus.sel = 1'b0; bus.nrd = 1'b1;
    d = bus.rdata;
  endtask

  task automatic enc_phase(input logic [1:0] ab);
    {enc_a, enc_b} = ab;
    idle(4);
  endtask

  // Counts clocks from the W1C edge until the timer bit reasserts.
  task automatic measure(output int n);
    n = 1;
    while (!irq && n < 12) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          n;

    bus.sel = 1'b0; bus.addr = '0; bus.nrd = 1'b1; bus.nwr = 4'hF; bus.wdata = '0;
    in_pins = 3'b111; {enc_a, enc_b} = 2'b11; od_in = 2'b11;

    idle(2);
    check("rst_od_release", 32'(od_release), 32'h3);
    check("rst_out_pins",   32'(out_pins),   32'h1);
    check("rst_irq",        32'(irq),        32'h0);
    check("rst_rdata",      bus.rdata,       32'h0);
    rst = 1'b0;
    idle(3);

    rd(A_RELOAD, d); check("rst_reload", d, 32'h007F_FFFF);
    idle(2);         check("rdata_hold", bus.rdata, 32'h007F_FFFF);
    rd(A_INPUT, d);  check("input_idle", d, 32'h0303_0007);
    od_in = 2'b01; idle(3);
    rd(A_INPUT, d);  check("input_od_sync", d, 32'h0301_0007);
    od_in = 2'b11;

    wr(A_OUTPUT, 4'b1011, 32'h0000_0000);
    check("od_lane2_clear", 32'(od_release), 32'h0);
    check("out_lane2_keep", 32'(out_pins),   32'h1);
    wr(A_OUTPUT, 4'b1011, 32'h0003_0000);
    check("od_lane2_set",   32'(od_release), 32'h3);
    wr(A_OUTPUT, 4'b1110, 32'h0000_0000);
    check("out_lane0_clear", 32'(out_pins),  32'h0);
    rd(A_OUTPUT, d); check("output_read", d, 32'h0003_0000);

    enc_phase(2'b00);
    rd(A_ENC, d); check("enc_jump_11_00", d, 32'h0);
    enc_phase(2'b01); enc_phase(2'b11); enc_phase(2'b10); enc_phase(2'b00);
    rd(A_ENC, d); check("enc_fwd4", d, 32'h4);
    rd(A_STAT, d); check("stat_enc_step", d, 32'h2);
    wr(A_STAT, 4'b1110, 32'h2);
    rd(A_STAT, d); check("stat_w1c_enc", d, 32'h0);
    wr(A_ENC, 4'b0000, 32'h0);
    enc_phase(2'b10);
    rd(A_ENC, d); check("enc_rev1", d, 32'hFFFF_FFFF);
    enc_phase(2'b11); enc_phase(2'b01); enc_phase(2'b00);
    rd(A_ENC, d); check("enc_rev4", d, 32'hFFFF_FFFC);
    enc_phase(2'b11);
    rd(A_ENC, d); check("enc_jump_00_11", d, 32'hFFFF_FFFC);
    wr(A_ENC, 4'b0000, 32'h0000_7FFF);
    enc_phase(2'b10);
    rd(A_ENC, d); check("enc_wrap_sign", d, 32'hFFFF_8000);
    enc_phase(2'b11);
    rd(A_ENC, d); check("enc_back", d, 32'h0000_7FFF);
    wr(A_STAT, 4'b1110, 32'h2);

    in_pins[0] = 1'b0; idle(4); in_pins[0] = 1'b1; idle(12);
    rd(A_INPUT, d); check("db_glitch", d, 32'h0303_0007);
    rd(A_STAT, d);  check("db_glitch_stat", d, 32'h0);
    wr(A_EN, 4'b1110, 32'h4);
    in_pins[0] = 1'b0;
    idle(9);        check("db_irq_early", 32'(irq), 32'h0);
    idle(1);        check("db_irq_set",   32'(irq), 32'h1);
    rd(A_INPUT, d); check("db_input", d, 32'h0303_0006);
    rd(A_STAT, d);  check("db_stat", d, 32'h4);
    wr(A_STAT, 4'b1110, 32'h4);
    check("db_irq_w1c", 32'(irq), 32'h0);

    wr(A_EN, 4'b1110, 32'h1);
    wr(A_RELOAD, 4'b0000, 32'h3);
    rd(A_RELOAD, d); check("reload_rd", d, 32'h3);
    n = 0;
    while (!irq && n < 10) begin @(negedge clk); n++; end
    check("tmr_first_evt", 32'(irq), 32'h1);
    wr(A_STAT, 4'b1110, 32'h1); measure(n);
    wr(A_STAT, 4'b1110, 32'h1); measure(n); check("tmr_period_a", 32'(n), 32'd4);
    wr(A_STAT, 4'b1110, 32'h1); measure(n); check("tmr_period_b", 32'(n), 32'd4);
    idle(3);
    wr(A_STAT, 4'b1110, 32'h1);
    check("w1c_vs_expiry", 32'(irq), 32'h1);
    rd(A_STAT, d); check("w1c_vs_expiry_stat", d, 32'h1);
    wr(A_RELOAD, 4'b0000, 32'h0);
    wr(A_STAT, 4'b1110, 32'h1);
    idle(20);
    check("reload0_no_evt", 32'(irq), 32'h0);

    wr(A_OUTPUT, 4'b1011, 32'h0);
    wr(A_ENC, 4'b0000, 32'h5);
    wr(A_RELOAD, 4'b0000, 32'h3);
    idle(6);
    check("pre_rst_irq", 32'(irq), 32'h1);
    rd(A_ENC, d); check("pre_rst_enc", d, 32'h5);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_od_release", 32'(od_release), 32'h3);
    check("mid_rst_out_pins",   32'(out_pins),   32'h1);
    check("mid_rst_irq",        32'(irq),        32'h0);
    check("mid_rst_rdata",      bus.rdata,       32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(A_ENC, d);    check("mid_rst_enc", d, 32'h0);
    rd(A_RELOAD, d); check("mid_rst_reload", d, 32'h007F_FFFF);
    rd(A_EN, d);     check("mid_rst_en", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
